// File: rtl/pe_cluster_seq.sv
// Tap/pixel sequencer for a 4-channel PE cluster running a KxK convolution layer.
// It issues operand addresses, drives the cluster controls one cycle later, and hands each pixel to writeback.
module pe_cluster_seq #(
   parameter int DIM_W   = 8,
   parameter int ADDR_W  = 16,
   parameter int MAC_LAT = 2
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              start,
   input  logic [DIM_W-1:0]  cfg_in_h,
   input  logic [DIM_W-1:0]  cfg_in_w,
   input  logic [DIM_W-1:0]  cfg_cin,
   input  logic [1:0]        cfg_k,
   input  logic [1:0]        cfg_stride,
   input  logic              cfg_pad,
   input  logic [DIM_W-1:0]  cfg_out_h,
   input  logic [DIM_W-1:0]  cfg_out_w,
   output logic              busy,
   output logic              done,
   output logic              act_rd,
   output logic [ADDR_W-1:0] act_addr,
   output logic              w_rd,
   output logic [ADDR_W-1:0] w_addr,
   output logic              pe_en,
   output logic              pe_clear_acc,
   output logic              pe_is_padding,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DIM_W-1:0]  res_oy,
   output logic [DIM_W-1:0]  res_ox
);
   localparam int CW  = DIM_W + 3;
   localparam int DCW = $clog2(MAC_LAT + 1) + 1;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT, S_FIN} state_t;
   state_t state;

   logic [DIM_W-1:0]  in_h_r, in_w_r, cin_r, out_h_r, out_w_r;
   logic [1:0]        k_r, stride_r;
   logic              pad_r;
   logic [DIM_W-1:0]  c, ox, oy;
   logic [1:0]        kx, ky;
   logic [DCW-1:0]    drain_cnt;

   logic [CW-1:0]     uy, ux, iy, ix;
   logic              issuing, tap_pad, first_tap, last_tap, last_pix;
   logic [ADDR_W-1:0] tap_act_addr, tap_w_addr;

   // Coordinates are kept unsigned: a tap lies above/left of the map exactly when
   // the unpadded sum is smaller than the pad, so no signed arithmetic is needed.
   always_comb begin
      issuing      = (state == S_ISSUE);
      uy           = CW'(oy) * CW'(stride_r) + CW'(ky);
      ux           = CW'(ox) * CW'(stride_r) + CW'(kx);
      iy           = uy - CW'(pad_r);
      ix           = ux - CW'(pad_r);
      tap_pad      = (uy < CW'(pad_r)) || (ux < CW'(pad_r)) ||
                     (iy >= CW'(in_h_r)) || (ix >= CW'(in_w_r));
      tap_act_addr = (ADDR_W'(iy) * ADDR_W'(in_w_r) + ADDR_W'(ix)) * ADDR_W'(cin_r) + ADDR_W'(c);
      tap_w_addr   = (ADDR_W'(ky) * ADDR_W'(k_r) + ADDR_W'(kx)) * ADDR_W'(cin_r) + ADDR_W'(c);
      first_tap    = (c == '0) && (kx == 2'd0) && (ky == 2'd0);
      last_tap     = (c == cin_r - DIM_W'(1)) && (kx == k_r - 2'd1) && (ky == k_r - 2'd1);
      last_pix     = (ox == out_w_r - DIM_W'(1)) && (oy == out_h_r - DIM_W'(1));
   end

   assign act_rd   = issuing & ~tap_pad;
   assign act_addr = act_rd ? tap_act_addr : '0;
   assign w_rd     = issuing;
   assign w_addr   = issuing ? tap_w_addr : '0;
   assign res_oy   = oy;
   assign res_ox   = ox;

   always_ff @(posedge aclk) begin
      if (areset) begin
         state         <= S_IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         pe_en         <= 1'b0;
         pe_clear_acc  <= 1'b0;
         pe_is_padding <= 1'b0;
         res_valid     <= 1'b0;
         in_h_r        <= '0;
         in_w_r        <= '0;
         cin_r         <= '0;
         out_h_r       <= '0;
         out_w_r       <= '0;
         k_r           <= '0;
         stride_r      <= '0;
         pad_r         <= 1'b0;
         c             <= '0;
         kx            <= '0;
         ky            <= '0;
         ox            <= '0;
         oy            <= '0;
         drain_cnt     <= '0;
      end else begin
         pe_en         <= 1'b0;
         pe_clear_acc  <= 1'b0;
         pe_is_padding <= 1'b0;
         done          <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  in_h_r   <= cfg_in_h;
                  in_w_r   <= cfg_in_w;
                  cin_r    <= cfg_cin;
                  out_h_r  <= cfg_out_h;
                  out_w_r  <= cfg_out_w;
                  k_r      <= cfg_k;
                  stride_r <= cfg_stride;
                  pad_r    <= (cfg_k == 2'd1) ? 1'b0 : cfg_pad;
                  c        <= '0;
                  kx       <= '0;
                  ky       <= '0;
                  ox       <= '0;
                  oy       <= '0;
                  busy     <= 1'b1;
                  state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               pe_en         <= 1'b1;
               pe_clear_acc  <= first_tap;
               pe_is_padding <= tap_pad;
               if (last_tap) begin
                  c         <= '0;
                  kx        <= '0;
                  ky        <= '0;
                  drain_cnt <= '0;
                  state     <= S_DRAIN;
               end else if (c != cin_r - DIM_W'(1)) begin
                  c <= c + DIM_W'(1);
               end else if (kx != k_r - 2'd1) begin
                  c  <= '0;
                  kx <= kx + 2'd1;
               end else begin
                  c  <= '0;
                  kx <= '0;
                  ky <= ky + 2'd1;
               end
            end
            // Wait out the last operand's register stage plus the MAC pipeline.
            S_DRAIN: begin
               if (drain_cnt == DCW'(MAC_LAT)) begin
                  res_valid <= 1'b1;
                  state     <= S_OUT;
               end else begin
                  drain_cnt <= drain_cnt + DCW'(1);
               end
            end
            S_OUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (last_pix) begin
                     done  <= 1'b1;
                     state <= S_FIN;
                  end else begin
                     if (ox == out_w_r - DIM_W'(1)) begin
                        ox <= '0;
                        oy <= oy + DIM_W'(1);
                     end else begin
                        ox <= ox + DIM_W'(1);
                     end
                     state <= S_ISSUE;
                  end
               end
            end
            S_FIN: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pe_cluster_seq.sv
// Bench for pe_cluster_seq: a cycle timeline is built from the layer rules (pixels, taps,
// drain, result hold) and every output is compared against it, with results scoreboarded in order.
module tb_pe_cluster_seq;
   localparam int DIM_W   = 8;
   localparam int ADDR_W  = 16;
   localparam int MAC_LAT = 2;
   localparam int MAXC    = 8192;

   logic              aclk = 1'b0;
   logic              areset = 1'b1;
   logic              start = 1'b0;
   logic [DIM_W-1:0]  cfg_in_h = '0, cfg_in_w = '0, cfg_cin = '0, cfg_out_h = '0, cfg_out_w = '0;
   logic [1:0]        cfg_k = '0, cfg_stride = '0;
   logic              cfg_pad = 1'b0;
   logic              res_ready = 1'b0;
   logic              busy, done, act_rd, w_rd, pe_en, pe_clear_acc, pe_is_padding, res_valid;
   logic [ADDR_W-1:0] act_addr, w_addr;
   logic [DIM_W-1:0]  res_oy, res_ox;

   pe_cluster_seq #(.DIM_W(DIM_W), .ADDR_W(ADDR_W), .MAC_LAT(MAC_LAT)) dut (
      .aclk(aclk), .areset(areset), .start(start),
      .cfg_in_h(cfg_in_h), .cfg_in_w(cfg_in_w), .cfg_cin(cfg_cin), .cfg_k(cfg_k),
      .cfg_stride(cfg_stride), .cfg_pad(cfg_pad), .cfg_out_h(cfg_out_h), .cfg_out_w(cfg_out_w),
      .busy(busy), .done(done), .act_rd(act_rd), .act_addr(act_addr), .w_rd(w_rd), .w_addr(w_addr),
      .pe_en(pe_en), .pe_clear_acc(pe_clear_acc), .pe_is_padding(pe_is_padding),
      .res_valid(res_valid), .res_ready(res_ready), .res_oy(res_oy), .res_ox(res_ox)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      bit                wrd, ard, en, clr, pad, rv, done, busy, rdy;
      logic [ADDR_W-1:0] aaddr, waddr;
      logic [DIM_W-1:0]  oy, ox;
   } cyc_t;

   cyc_t              tl[MAXC];
   int                tl_len;
   logic [2*DIM_W-1:0] exp_q[$];
   int                m_in_h, m_in_w, m_cin, m_k, m_s, m_p, m_oh, m_ow;
   int                n_cmp = 0, n_err = 0;
   logic [8:0]        pad_bits;
   int                en_seen, act_max;
   logic [ADDR_W-1:0] act_seen[$];

   task set_cfg(input int ih, input int iw, input int cin, input int k, input int s, input int p);
      int pe;
      m_in_h = ih; m_in_w = iw; m_cin = cin; m_k = k; m_s = s; m_p = p;
      pe   = (k == 1) ? 0 : p;
      m_oh = (ih + 2 * pe - k) / s + 1;
      m_ow = (iw + 2 * pe - k) / s + 1;
   endtask

   // Expected cycle-by-cycle behaviour, counted from the cycle after the accepted start.
   task build_model(input int stall_max, input int fix_pix, input int fix_len);
      int cyc, pix, tap, pe, iy, ix, stall;
      bit pd;
      for (int i = 0; i < MAXC; i++) begin
         tl[i] = '{default: 0};
         tl[i].rdy = 1'($urandom_range(0, 1));
      end
      exp_q.delete();
      cyc = 0; pix = 0;
      pe  = (m_k == 1) ? 0 : m_p;
      for (int oy = 0; oy < m_oh; oy++) begin
         for (int ox = 0; ox < m_ow; ox++) begin
            tap = 0;
            for (int ky = 0; ky < m_k; ky++)
               for (int kx = 0; kx < m_k; kx++)
                  for (int c = 0; c < m_cin; c++) begin
                     iy = oy * m_s + ky - pe;
                     ix = ox * m_s + kx - pe;
                     pd = (iy < 0) || (iy >= m_in_h) || (ix < 0) || (ix >= m_in_w);
                     tl[cyc].busy  = 1;
                     tl[cyc].wrd   = 1;
                     tl[cyc].ard   = !pd;
                     tl[cyc].aaddr = pd ? '0 : ADDR_W'((iy * m_in_w + ix) * m_cin + c);
                     tl[cyc].waddr = ADDR_W'((ky * m_k + kx) * m_cin + c);
                     tl[cyc+1].en  = 1;
                     tl[cyc+1].clr = (tap == 0);
                     tl[cyc+1].pad = pd;
                     cyc++; tap++;
                  end
            for (int d = 0; d <= MAC_LAT; d++) begin
               tl[cyc].busy = 1;
               cyc++;
            end
            stall = (pix == fix_pix) ? fix_len : int'($urandom_range(0, stall_max));
            for (int j = 0; j <= stall; j++) begin
               tl[cyc].busy = 1;
               tl[cyc].rv   = 1;
               tl[cyc].oy   = DIM_W'(oy);
               tl[cyc].ox   = DIM_W'(ox);
               tl[cyc].rdy  = (j == stall);
               cyc++;
            end
            exp_q.push_back({DIM_W'(oy), DIM_W'(ox)});
            pix++;
         end
      end
      tl[cyc].busy = 1;
      tl[cyc].done = 1;
      tl_len = cyc + 4;
   endtask

   task run_layer(input int abort_at, input int inject_at);
      logic [ADDR_W-1:0]  wa, aa;
      logic [2*DIM_W-1:0] want;
      bit                 quiet;
      en_seen = 0; pad_bits = '0; act_max = 0; act_seen.delete();
      @(negedge aclk);
      cfg_in_h = DIM_W'(m_in_h); cfg_in_w = DIM_W'(m_in_w); cfg_cin = DIM_W'(m_cin);
      cfg_k = 2'(m_k); cfg_stride = 2'(m_s); cfg_pad = 1'(m_p);
      cfg_out_h = DIM_W'(m_oh); cfg_out_w = DIM_W'(m_ow);
      start = 1'b1;
      for (int i = 0; i < tl_len; i++) begin
         @(negedge aclk);
         start = (i == inject_at);
         if (i == inject_at) begin
            cfg_in_h = DIM_W'($urandom_range(1, 9)); cfg_in_w = DIM_W'($urandom_range(1, 9));
            cfg_cin = DIM_W'($urandom_range(1, 5)); cfg_k = 2'd3; cfg_stride = 2'd2;
            cfg_pad = 1'b0; cfg_out_h = DIM_W'(1); cfg_out_w = DIM_W'(1);
         end
         res_ready = tl[i].rdy;
         wa = w_rd ? w_addr : '0;
         aa = act_rd ? act_addr : '0;
         n_cmp++;
         if ({w_rd, act_rd, wa, aa} !== {tl[i].wrd, tl[i].ard, tl[i].waddr, tl[i].aaddr}) begin
            n_err++;
            $display("FAIL issue cyc=%0d got w_rd=%b act_rd=%b w_addr=%0d act_addr=%0d exp %b %b %0d %0d",
                     i, w_rd, act_rd, wa, aa, tl[i].wrd, tl[i].ard, tl[i].waddr, tl[i].aaddr);
         end
         n_cmp++;
         if ({pe_en, pe_en & pe_clear_acc, pe_en & pe_is_padding} !== {tl[i].en, tl[i].clr, tl[i].pad}) begin
            n_err++;
            $display("FAIL pe_ctl cyc=%0d got en/clr/pad=%b%b%b exp %b%b%b", i,
                     pe_en, pe_clear_acc, pe_is_padding, tl[i].en, tl[i].clr, tl[i].pad);
         end
         n_cmp++;
         if ({busy, done, res_valid} !== {tl[i].busy, tl[i].done, tl[i].rv}) begin
            n_err++;
            $display("FAIL status cyc=%0d got busy/done/res_valid=%b%b%b exp %b%b%b", i,
                     busy, done, res_valid, tl[i].busy, tl[i].done, tl[i].rv);
         end
         if (tl[i].rv) begin
            n_cmp++;
            if ({res_oy, res_ox} !== {tl[i].oy, tl[i].ox}) begin
               n_err++;
               $display("FAIL res_coord cyc=%0d got (%0d,%0d) exp (%0d,%0d)", i, res_oy, res_ox, tl[i].oy, tl[i].ox);
            end
         end
         if (res_valid && res_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL res_extra cyc=%0d got (%0d,%0d) exp none", i, res_oy, res_ox);
            end else begin
               want = exp_q.pop_front();
               if ({res_oy, res_ox} !== want) begin
                  n_err++;
                  $display("FAIL res_order cyc=%0d got (%0d,%0d) exp (%0d,%0d)", i, res_oy, res_ox,
                           want[2*DIM_W-1:DIM_W], want[DIM_W-1:0]);
               end
            end
         end
         if (pe_en && en_seen < 9) begin
            pad_bits[en_seen] = pe_is_padding;
            en_seen++;
         end
         if (act_rd && i < 9) act_seen.push_back(act_addr);
         if (act_rd && int'(act_addr) > act_max) act_max = int'(act_addr);
         if (i == abort_at) begin
            areset = 1'b1;
            @(negedge aclk);
            n_cmp++;
            if ({busy, done, act_rd, act_addr, w_rd, w_addr, pe_en, pe_clear_acc, pe_is_padding,
                 res_valid, res_oy, res_ox} !== '0) begin
               n_err++;
               $display("FAIL abort_zero got busy=%b done=%b act_rd=%b w_rd=%b pe_en=%b res_valid=%b exp all 0",
                        busy, done, act_rd, w_rd, pe_en, res_valid);
            end
            areset = 1'b0;
            quiet = 1'b0;
            repeat (15) begin
               @(negedge aclk);
               quiet = quiet | busy | done;
            end
            n_cmp++;
            if (quiet !== 1'b0) begin
               n_err++;
               $display("FAIL abort_quiet got busy_or_done=%b exp 0", quiet);
            end
            return;
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL res_missing got %0d results outstanding exp 0", exp_q.size());
      end
   endtask

   task test_reset();
      @(negedge aclk);
      n_cmp++;
      if ({busy, done, act_rd, act_addr, w_rd, w_addr, pe_en, pe_clear_acc, pe_is_padding,
           res_valid, res_oy, res_ox} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs got busy=%b act_rd=%b w_rd=%b pe_en=%b res_valid=%b exp all 0",
                  busy, act_rd, w_rd, pe_en, res_valid);
      end
      @(negedge aclk);
      areset = 1'b0;
      repeat (3) @(negedge aclk);
      n_cmp++;
      if ({busy, done, w_rd, pe_en, res_valid} !== 5'b0) begin
         n_err++;
         $display("FAIL idle_after_reset got %b exp 00000", {busy, done, w_rd, pe_en, res_valid});
      end
   endtask

   task test_basic();
      set_cfg(4, 4, 1, 3, 1, 1);
      build_model(0, -1, 0);
      run_layer(-1, -1);
      n_cmp++;
      if (pad_bits !== 9'b001001111) begin
         n_err++;
         $display("FAIL pix0_padding got %b exp 001001111", pad_bits);
      end
      n_cmp++;
      if (act_seen.size() != 4 || act_seen[0] !== 16'd0 || act_seen[1] !== 16'd1 ||
          act_seen[2] !== 16'd4 || act_seen[3] !== 16'd5) begin
         n_err++;
         $display("FAIL pix0_act_addr got %0d reads first=%0d exp 4 reads 0,1,4,5",
                  act_seen.size(), (act_seen.size() > 0) ? act_seen[0] : 16'hffff);
      end
      n_cmp++;
      if (act_max > 15) begin
         n_err++;
         $display("FAIL act_addr_range got max %0d exp <= 15", act_max);
      end
   endtask

   task test_cin3_k1();
      set_cfg(4, 4, 3, 1, 2, 1);
      build_model(2, -1, 0);
      run_layer(-1, -1);
   endtask

   task test_stall();
      set_cfg(4, 4, 1, 3, 1, 1);
      build_model(3, 1, 5);
      run_layer(-1, -1);
   endtask

   task test_abort();
      set_cfg(4, 4, 1, 3, 1, 1);
      build_model(0, -1, 0);
      run_layer(5 * 13 + 3, -1);
      build_model(0, -1, 0);
      run_layer(-1, -1);
   endtask

   task test_start_busy();
      set_cfg(4, 4, 3, 1, 2, 1);
      build_model(1, -1, 0);
      run_layer(-1, 10);
   endtask

   task test_random();
      for (int r = 0; r < 4; r++) begin
         set_cfg($urandom_range(3, 6), $urandom_range(3, 6), $urandom_range(1, 4),
                 ($urandom_range(0, 1) == 1) ? 3 : 1, $urandom_range(1, 2), $urandom_range(0, 1));
         build_model(3, -1, 0);
         run_layer(-1, -1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_cin3_k1();
      test_stall();
      test_abort();
      test_start_busy();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
